// File: rtl/demux_frame_sequencer.sv
// Serializes a parallel word MSB-first toward a 1-to-4 demux, holding the select pair for the frame.
// Optional: define DEMUX_SEQ_PARITY_EN to append an even-parity bit after the LSB of every frame.
module demux_frame_sequencer #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_ch,
   input  logic [WIDTH-1:0] in_data,
   output logic             s1,
   output logic             s2,
   output logic             d,
   output logic             strobe,
   output logic             busy,
   output logic             frame_done
);

   localparam int unsigned CW = $clog2(WIDTH + 2);
`ifdef DEMUX_SEQ_PARITY_EN
   localparam int unsigned FLEN = WIDTH + 1;
`else
   localparam int unsigned FLEN = WIDTH;
`endif
   localparam int unsigned LAST     = FLEN - 1;
   localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

   state_e           state_q, state_d;
   // Holds the bits still to be sent; the bit currently on d has already left it.
   logic [WIDTH-2:0] shreg_q, shreg_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [3:0]       gap_cnt_q, gap_cnt_d;
   logic             s1_q, s1_d, s2_q, s2_d, d_q, d_d;
   logic             strobe_q, strobe_d, busy_q, busy_d, fd_q, fd_d;
`ifdef DEMUX_SEQ_PARITY_EN
   logic             par_q, par_d;
`endif

   assign in_ready   = (state_q == IDLE) && !rst;
   assign s1         = s1_q;
   assign s2         = s2_q;
   assign d          = d_q;
   assign strobe     = strobe_q;
   assign busy       = busy_q;
   assign frame_done = fd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         d_q       <= 1'b0;
         strobe_q  <= 1'b0;
         busy_q    <= 1'b0;
         fd_q      <= 1'b0;
`ifdef DEMUX_SEQ_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         d_q       <= d_d;
         strobe_q  <= strobe_d;
         busy_q    <= busy_d;
         fd_q      <= fd_d;
`ifdef DEMUX_SEQ_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   // Next state plus next registered outputs; outputs default to their idle values.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      s1_d      = 1'b0;
      s2_d      = 1'b0;
      d_d       = 1'b0;
      strobe_d  = 1'b0;
      busy_d    = 1'b0;
      fd_d      = 1'b0;
`ifdef DEMUX_SEQ_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               state_d   = SHIFT;
               shreg_d   = in_data[WIDTH-2:0];
               bit_cnt_d = '0;
               gap_cnt_d = '0;
               s1_d      = in_ch[1];
               s2_d      = in_ch[0];
               d_d       = in_data[WIDTH-1];
               strobe_d  = 1'b1;
               busy_d    = 1'b1;
`ifdef DEMUX_SEQ_PARITY_EN
               par_d     = ^in_data;
`endif
            end
         end
         SHIFT: begin
            if (bit_cnt_q == CW'(LAST)) begin
               if (GAP_CYCLES > 0) begin
                  state_d   = GAP;
                  gap_cnt_d = '0;
                  s1_d      = s1_q;
                  s2_d      = s2_q;
                  busy_d    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
               shreg_d   = shreg_q << 1;
               s1_d      = s1_q;
               s2_d      = s2_q;
               d_d       = shreg_q[WIDTH-2];
               strobe_d  = 1'b1;
               busy_d    = 1'b1;
               fd_d      = (bit_cnt_q == CW'(LAST - 1));
`ifdef DEMUX_SEQ_PARITY_EN
               if (bit_cnt_q == CW'(WIDTH - 1)) d_d = par_q;
`endif
            end
         end
         GAP: begin
            if (gap_cnt_q == 4'(GAP_LAST)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
               s1_d      = s1_q;
               s2_d      = s2_q;
               busy_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
